// File: rtl/matrix_loader.sv
// matrix_loader: assembles a DIMxDIM matrix of ELEM_W-bit elements from a
// valid/ready byte stream (column-major) and holds it until accepted.
// Ports:
//   clk, rst (async active-high)
//   tamanho   logical size, sampled on the first byte of each matrix
//   abort     synchronous clear of a load in progress
//   in_data/in_valid/in_ready    upstream element stream
//   matriz/out_valid/out_ready   flattened matrix to downstream
//   size_err  one-cycle pulse when a sampled tamanho is out of range
module matrix_loader #(
    parameter int DIM    = 5,
    parameter int ELEM_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2:0]                tamanho,
    input  logic                      abort,
    input  logic [ELEM_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [ELEM_W*DIM*DIM-1:0] matriz,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      size_err
);

    typedef enum logic {LOAD, FULL} state_t;

    state_t state, state_nxt;

    logic [2:0] coluna, linha, size_q;
    logic [2:0] cur_size;
    logic       accept, first, bad_size;
    logic       last_row, last_col;
    logic [ELEM_W*DIM*DIM-1:0] matriz_nxt;

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == FULL);

    // The size used for wrap decisions on the first byte is the freshly
    // sampled one, since size_q only updates on that same edge.
    always_comb begin
        accept   = in_valid && (state == LOAD) && !abort;
        first    = (coluna == 3'd0) && (linha == 3'd0);
        bad_size = (tamanho < 3'd2) || (tamanho > 3'(DIM));
        if (first)
            cur_size = bad_size ? 3'(DIM) : tamanho;
        else
            cur_size = size_q;
        last_row = (linha == cur_size - 3'd1);
        last_col = (coluna == cur_size - 3'd1);
    end

    // First byte clears the whole matrix so unused positions read as zero.
    always_comb begin
        int bitpos;
        bitpos = (int'(linha) + DIM * int'(coluna)) * ELEM_W;
        matriz_nxt = first ? '0 : matriz;
        matriz_nxt[bitpos +: ELEM_W] = in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= LOAD;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD: if (accept && last_row && last_col) state_nxt = FULL;
            FULL: if (out_ready) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coluna   <= 3'd0;
            linha    <= 3'd0;
            size_q   <= 3'(DIM);
            matriz   <= '0;
            size_err <= 1'b0;
        end else begin
            size_err <= accept && first && bad_size;
            if ((state == LOAD) && abort) begin
                coluna <= 3'd0;
                linha  <= 3'd0;
            end else if (accept) begin
                if (first)
                    size_q <= cur_size;
                matriz <= matriz_nxt;
                if (last_row) begin
                    linha  <= 3'd0;
                    coluna <= last_col ? 3'd0 : coluna + 3'd1;
                end else begin
                    linha <= linha + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_loader.sv
// tb_matrix_loader: directed/random stimulus for matrix_loader checked
// against a column-major reference model of the assembled matrix.
module tb_matrix_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   tamanho;
    logic         abort;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [199:0] matriz;
    logic         out_valid;
    logic         out_ready;
    logic         size_err;

    int total = 0;
    int bad   = 0;

    matrix_loader dut (
        .clk      (clk),
        .rst      (rst),
        .tamanho  (tamanho),
        .abort    (abort),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .matriz   (matriz),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .size_err (size_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(string tag, logic [199:0] obs, logic [199:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int eff(int tam);
        return (tam < 2 || tam > 5) ? 5 : tam;
    endfunction

    // Element k of the stream lands at column k/n, row k%n.
    function automatic logic [199:0] model(int tam, logic [7:0] q[$]);
        logic [199:0] m;
        int n;
        n = eff(tam);
        m = '0;
        for (int k = 0; k < q.size(); k++)
            m[8*((k % n) + 5*(k / n)) +: 8] = q[k];
        return m;
    endfunction

    task automatic send(int tam, logic [7:0] q[$], bit gaps);
        int n;
        n = eff(tam);
        for (int i = 0; i < q.size(); i++) begin
            if (gaps && $urandom_range(1, 0) == 1) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(posedge clk); #1;
            end
            tamanho = (i == 0) ? 3'(tam) : 3'($urandom);
            chk("in_ready", {199'd0, in_ready}, 200'd1);
            in_valid = 1'b1;
            in_data  = q[i];
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (i == 0)
                chk("size_err", {199'd0, size_err},
                    200'(tam < 2 || tam > 5));
            if (i == 1)
                chk("size_err_clr", {199'd0, size_err}, 200'd0);
            chk("out_valid", {199'd0, out_valid}, 200'(i == n*n - 1));
        end
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("ready_after_handoff", {199'd0, in_ready}, 200'd1);
        chk("valid_after_handoff", {199'd0, out_valid}, 200'd0);
    endtask

    initial begin
        logic [7:0]   q[$];
        logic [199:0] exp;

        rst = 1'b1; tamanho = 3'd5; abort = 1'b0;
        in_data = 8'd0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_matriz", matriz, 200'd0);
        chk("rst_out_valid", {199'd0, out_valid}, 200'd0);
        chk("rst_size_err", {199'd0, size_err}, 200'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", {199'd0, in_ready}, 200'd1);

        // 5x5 sequential bytes 1..25
        q = {};
        for (int i = 1; i <= 25; i++) q.push_back(8'(i));
        send(5, q, 1'b0);
        exp = model(5, q);
        chk("m5_full", matriz, exp);
        chk("m5_e00", {192'd0, matriz[7:0]}, 200'd1);
        chk("m5_e01", {192'd0, matriz[15:8]}, 200'd2);
        chk("m5_e44", {192'd0, matriz[199:192]}, 200'd25);

        // FULL hold with garbage input and an ignored abort
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            abort    = (i == 4);
            @(posedge clk); #1;
            chk("hold_matriz", matriz, exp);
            chk("hold_in_ready", {199'd0, in_ready}, 200'd0);
            chk("hold_out_valid", {199'd0, out_valid}, 200'd1);
        end
        in_valid = 1'b0;
        abort = 1'b0;
        handoff();
        chk("matriz_kept", matriz, exp);

        // 3x3 bytes 0x81..0x89
        q = {};
        for (int i = 0; i < 9; i++) q.push_back(8'(8'h81 + i));
        send(3, q, 1'b0);
        chk("m3_full", matriz, model(3, q));
        chk("m3_e10", {192'd0, matriz[47:40]}, 200'h84);
        chk("m3_e22", {192'd0, matriz[103:96]}, 200'h89);
        handoff();

        // 4x4 random bytes with random valid gaps
        for (int r = 0; r < 3; r++) begin
            q = {};
            for (int i = 0; i < 16; i++) q.push_back(8'($urandom));
            send(4, q, 1'b1);
            chk("m4_gaps", matriz, model(4, q));
            handoff();
        end

        // 7 bytes, abort with a discarded byte, then 2x2 load
        q = {};
        for (int i = 0; i < 7; i++) q.push_back(8'($urandom) | 8'h01);
        send(5, q, 1'b0);
        exp = model(5, q);
        chk("partial", matriz, exp);
        abort = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_matriz", matriz, exp);
        chk("abort_in_ready", {199'd0, in_ready}, 200'd1);
        q = '{8'h10, 8'h11, 8'h12, 8'h13};
        send(2, q, 1'b0);
        exp = '0;
        exp[7:0] = 8'h10; exp[15:8] = 8'h11;
        exp[47:40] = 8'h12; exp[55:48] = 8'h13;
        chk("m2_const", matriz, exp);
        chk("m2_model", matriz, model(2, q));
        handoff();

        // out-of-range sizes fall back to 5x5
        for (int t = 0; t < 2; t++) begin
            q = {};
            for (int i = 0; i < 25; i++) q.push_back(8'($urandom));
            send(t == 0 ? 7 : 1, q, 1'b1);
            chk("bad_size_full", matriz, model(7, q));
            handoff();
        end

        // reset mid-load after 12 bytes
        q = {};
        for (int i = 0; i < 12; i++) q.push_back(8'($urandom) | 8'h01);
        send(5, q, 1'b0);
        chk("pre_rst", matriz, model(5, q));
        rst = 1'b1;
        #1;
        chk("async_rst_matriz", matriz, 200'd0);
        chk("async_rst_valid", {199'd0, out_valid}, 200'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        q = {};
        for (int i = 0; i < 16; i++) q.push_back(8'($urandom));
        send(4, q, 1'b1);
        chk("post_rst_load", matriz, model(4, q));
        handoff();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matrix_loader.md
Name: matrix_loader

Overview:
- Upstream stage of the matrix operation units. It assembles a 5x5 matrix of signed 8-bit elements from a byte stream with a valid/ready handshake.
- It presents the matrix as a flattened 200-bit word. Element (coluna, linha) occupies bits [8*(linha+5*coluna) +: 8].
- The loaded matrix is held stable until the downstream consumer accepts it.
- Supports a logical size of 2..5. Unused positions are zero-padded.

Parameters:
- DIM, 5, physical matrix dimension; the flattened width is 8*DIM*DIM.
- ELEM_W, 8, element width in bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- tamanho  in  3  logical size (2..5); sampled on the first accepted byte of each matrix.
- abort  in  1  synchronous clear of a load in progress.
- in_data  in  8  incoming element (two's complement).
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader can accept a byte this cycle.
- matriz  out  200  flattened assembled matrix.
- out_valid  out  1  matriz is complete and stable.
- out_ready  in  1  downstream accepts the matrix.
- size_err  out  1  one-cycle pulse when a sampled tamanho is out of range.

Behaviour:
- States: LOAD and FULL.
- Reset (async, rst=1):
  - state=LOAD, coluna=0, linha=0, size_q=5.
  - matriz=0, out_valid=0, size_err=0.
  - in_ready=1 one cycle after rst is released.
- Accept rule: a byte is accepted on a rising edge where in_valid & in_ready. No other cycle changes the counters.
- in_ready = (state==LOAD). out_valid = (state==FULL). Both are registered-state decodes with no combinational path from in_valid or out_ready.
- First byte of a matrix (coluna==0 & linha==0):
  - size_q <= tamanho. If tamanho<2 or >5, size_q <= 5 and size_err pulses for 1 cycle.
  - The whole matriz is cleared to 0 in the same edge that writes element (0,0). This guarantees zero padding.
- Each accepted byte is written at matriz[8*(linha+5*coluna) +: 8], using the current counter values.
  - linha increments. When linha==size_q-1, linha <= 0 and coluna increments.
  - The stream is therefore column-major: all rows of coluna 0 first.
- Last byte is (coluna==size_q-1, linha==size_q-1):
  - The counters return to 0 and state <= FULL.
  - out_valid rises on the cycle after the edge that accepted the last byte. Latency is size_q*size_q accepted bytes to out_valid.
- FULL state:
  - matriz and out_valid hold stable. in_ready=0, so in_data is ignored regardless of in_valid.
  - On an edge with out_ready=1, state <= LOAD and in_ready=1 the next cycle.
  - matriz keeps its value after the handoff until the next first byte clears it.
- No bubble limit: in_valid may toggle arbitrarily mid-load. Gaps do not affect the result.
- abort=1 at an edge in LOAD: the counters return to 0, state stays LOAD, and matriz is unchanged. The next byte is treated as a first byte. A byte presented in the same cycle as abort is discarded.
- abort=1 in FULL is ignored. A held matrix is never discarded.
- rst asserted mid-load or in FULL: immediate return to reset values with no pending output.
- Elements are stored verbatim, with no sign manipulation. Downstream operators interpret them as signed.

Test Plan:
- Reset then tamanho=5, stream bytes 1..25 with in_valid held high:
  - in_ready stays 1 for 25 cycles, then out_valid=1.
  - matriz[7:0]=1, matriz[15:8]=2 (coluna0,linha1), matriz[199:192]=25.
- tamanho=3, stream 9 bytes 0x81..0x89:
  - element (1,0) at bits [47:40] = 0x84; element (2,2) at bits [103:96] = 0x89.
  - All 16 positions with coluna>=3 or linha>=3 are 0.
  - out_valid rises after the 9th byte.
- Hold out_ready=0 for 10 cycles in FULL while in_valid=1 with garbage data:
  - matriz is unchanged and in_ready=0.
  - out_ready=1 for 1 cycle, then in_ready=1 on the next cycle.
- Random in_valid gaps (about 50% duty) during a 4x4 load: the result is identical to the gap-free load of the same 16 bytes.
- Send 7 bytes, pulse abort, then send a full 2x2 load of 0x10..0x13:
  - matriz = 0x10 @ [7:0], 0x11 @ [15:8], 0x12 @ [47:40], 0x13 @ [55:48].
  - Everything else is 0.
- tamanho=7 on the first byte: size_err pulses once and 25 bytes are required.
- Assert rst mid-load at byte 12: outputs clear immediately. A fresh load after release completes correctly.
